timer_arbiter: RTL and testbench

//  Shares one millisecond timer instance among NUM_REQ requesters (LED blinkers, debouncers, UART timeouts).

---
 rtl/timer_arbiter_pkg.sv | 10 +
 rtl/rr_picker.sv | 29 ++
 rtl/timer_arbiter.sv | 114 +++++++++++
 tb/tb_timer_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arbiter_pkg.sv
// Shared types and defaults for the millisecond-timer arbiter.
// The state encoding is shared so the top and any future debug taps agree on it.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} tarb_state_t;

    localparam int DELAY_W_DEFAULT = 10;
    localparam int NUM_REQ_DEFAULT = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping modulo N.
// Pure logic, no state; valid_o is low when no request is set.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Scan farthest-first so the nearest set bit after ptr_i is the one left standing.
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one millisecond timer among NUM_REQ clients, round-robin, one owner at a time.
// Grant 1 cycle after request from IDLE; done pulses 1 cycle after timeout; 2 cycles to the next grant.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int DELAY_W = DELAY_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] delay_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       tmr_enable,
    output logic [DELAY_W-1:0]         tmr_delay,
    input  logic                       tmr_timeout
);

    localparam int            IW      = $clog2(NUM_REQ);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    tarb_state_t          state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 en_q, en_d;

    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        delay_d = delay_q;
        grant_d = grant_q;
        done_d  = '0;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    idx_d           = pick_idx;
                    ptr_d           = pick_idx;
                    delay_d         = delay_in[int'(pick_idx)*DELAY_W +: DELAY_W];
                    grant_d         = '0;
                    grant_d[pick_idx] = 1'b1;
                    en_d            = 1'b1;
                    state_d         = ARM;
                end
            end
            // The timer may still show the previous owner's timeout for a cycle.
            ARM: state_d = RUN;
            RUN: begin
                if (!req[idx_q]) begin
                    grant_d = '0;
                    en_d    = 1'b0;
                    state_d = IDLE;
                end else if (tmr_timeout) begin
                    grant_d        = '0;
                    done_d[idx_q]  = 1'b1;
                    en_d           = 1'b0;
                    state_d        = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                grant_d = '0;
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= PTR_RST;
            delay_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            delay_q <= delay_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            en_q    <= en_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = |grant_q;
    assign tmr_enable = en_q;
    assign tmr_delay  = delay_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized bench for timer_arbiter: service-level reference model feeds an event scoreboard.
// Includes a behavioural 1 ms = 2 clk timer.
module tb_timer_arbiter;

    localparam int N  = 4;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] delay_in;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          busy;
    logic          tmr_enable;
    logic [DW-1:0] tmr_delay;
    logic          tmr_timeout;

    timer_arbiter #(.NUM_REQ(N), .DELAY_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .delay_in    (delay_in),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .tmr_enable  (tmr_enable),
        .tmr_delay   (tmr_delay),
        .tmr_timeout (tmr_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer: counts clocks while enabled, cleared while disabled; 1 ms = 2 clocks.
    int tcnt = 0;
    always @(posedge clk) begin
        if (!tmr_enable) tcnt <= 0;
        else             tcnt <= tcnt + 1;
    end
    assign tmr_timeout = (tcnt >= 2 * int'(tmr_delay));

    typedef struct {
        int kind;    // 0 = grant, 1 = done
        int client;
        int cyc;
        int dly;
    } ev_t;

    ev_t exp_q[$];
    int  dly[N];
    int  last_owner;
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int first_after(input logic [N-1:0] s);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last_owner + k) % N;
            if (s[c]) return c;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: every client in s is held until its own done, so service
    // runs through s in cyclic order after the last owner.
    task automatic push_services(input logic [N-1:0] s, input int t);
        int g, c, run;
        g = t;
        for (int k = 1; k <= N; k++) begin
            c = (last_owner + k) % N;
            if (s[c]) begin
                run = (dly[c] == 0) ? 1 : 2 * dly[c];
                exp_q.push_back(ev_t'{0, c, g, dly[c]});
                exp_q.push_back(ev_t'{1, c, g + run + 1, dly[c]});
                g = g + run + 1 + 2;
            end
        end
        for (int k = 1; k <= N; k++) begin
            c = (last_owner + k) % N;
            if (s[c]) g = c;
        end
        if (s != '0) last_owner = g;
    endtask

    task automatic drive_dly();
        for (int i = 0; i < N; i++) delay_in[i*DW +: DW] = DW'(dly[i]);
    endtask

    // One clock of client behaviour: drop request after own done; garble delays while busy.
    task automatic tick();
        logic [63:0] junk;
        @(negedge clk);
        for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
        if (grant != '0) begin
            junk     = {$urandom, $urandom};
            delay_in = junk[N*DW-1:0];
        end else begin
            drive_dly();
        end
    endtask

    task automatic run_batch(input logic [N-1:0] s, input bit wd, input bit rnd);
        int w, c, t0, budget;
        logic [N-1:0] rest;
        if (rnd) for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 5);
        w = first_after(s);
        if (wd && dly[w] == 0) dly[w] = 1;
        drive_dly();
        req = s;
        t0  = cyc;
        if (wd) begin
            exp_q.push_back(ev_t'{0, w, t0 + 1, dly[w]});
            last_owner = w;
            c = t0 + 1 + $urandom_range(1, 2 * dly[w]);
            budget = 0;
            while (cyc < c && budget < 100) begin tick(); budget++; end
            req[w] = 1'b0;
            rest    = s;
            rest[w] = 1'b0;
            push_services(rest, c + 2);
            tick();
            check("withdraw_enable_off", int'(tmr_enable), 0);
            check("withdraw_grant_off", int'(grant), 0);
        end else begin
            push_services(s, t0 + 1);
        end
        budget = 0;
        while ((req != '0 || exp_q.size() != 0) && budget < 400) begin
            tick();
            budget++;
        end
        check("batch_complete", int'(req == '0 && exp_q.size() == 0), 1);
        req = '0;
        exp_q.delete();
        repeat (3) tick();
    endtask

    task automatic reset_episode();
        int w, t0;
        w = first_after(4'b1111);
        dly[w] = 5;
        drive_dly();
        req = '0;
        req[w] = 1'b1;
        t0 = cyc;
        exp_q.push_back(ev_t'{0, w, t0 + 1, dly[w]});
        repeat ($urandom_range(2, 6)) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_async_grant", int'(grant), 0);
        check("rst_async_done", int'(done), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_enable", int'(tmr_enable), 0);
        check("rst_async_delay", int'(tmr_delay), 0);
        exp_q.delete();
        req = '0;
        repeat (2) tick();
        rst = 1'b0;
        last_owner = N - 1;
        repeat (2) tick();
    endtask

    // Monitor / scoreboard
    logic [N-1:0] prev_grant = '0;
    int  cur_dly = 0;
    ev_t mev;
    always @(negedge clk) begin
        if (!rst) begin
            check("onehot0_grant", int'($onehot0(grant)), 1);
            check("onehot0_done", int'($onehot0(done)), 1);
            check("busy_eq_or_grant", int'(busy), int'(|grant));
            check("enable_eq_busy", int'(tmr_enable), int'(busy));
            if (grant != '0 && grant != prev_grant) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", idx_of(grant), -1);
                end else begin
                    mev = exp_q.pop_front();
                    check("grant_event_kind", 0, mev.kind);
                    check("grant_client", idx_of(grant), mev.client);
                    check("grant_cycle", cyc, mev.cyc);
                    check("grant_delay", int'(tmr_delay), mev.dly);
                    cur_dly = mev.dly;
                end
            end else if (grant != '0) begin
                check("delay_held", int'(tmr_delay), cur_dly);
            end
            if (done != '0) begin
                check("grant_clear_in_done", int'(grant), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", idx_of(done), -1);
                end else begin
                    mev = exp_q.pop_front();
                    check("done_event_kind", 1, mev.kind);
                    check("done_client", idx_of(done), mev.client);
                    check("done_cycle", cyc, mev.cyc);
                end
            end
        end
        prev_grant = grant;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rs;
        rst = 1'b1;
        req = '0;
        delay_in = '0;
        for (int i = 0; i < N; i++) dly[i] = 0;
        last_owner = N - 1;
        repeat (3) @(negedge clk);
        check("reset_grant", int'(grant), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_enable", int'(tmr_enable), 0);
        check("reset_delay", int'(tmr_delay), 0);
        rst = 1'b0;
        repeat (2) tick();

        // single client, 3 ms
        dly[0] = 3;
        run_batch(4'b0001, 1'b0, 1'b0);
        // all clients, 1 ms each
        for (int i = 0; i < N; i++) dly[i] = 1;
        run_batch(4'b1111, 1'b0, 1'b0);
        // owner 2 withdraws mid-run, client 3 waiting
        dly[2] = 4;
        dly[3] = 1;
        run_batch(4'b1100, 1'b1, 1'b0);
        // zero delays
        for (int i = 0; i < N; i++) dly[i] = 0;
        run_batch(4'b0011, 1'b0, 1'b0);
        // reset mid-run, then client 0 must win first
        reset_episode();
        run_batch(4'b1111, 1'b0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            rs = N'($urandom_range(1, (1 << N) - 1));
            run_batch(rs, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
